chip_emulator: RTL
==================

# chip_emulator

Synthesizable stand-in for a 14-pin quad 2-input gate chip, used on the bench side of the pin header in place of a real 74xx part. It samples the pins the checker drives, computes the selected gate function, and drives the chip's output pins after a programmable propagation delay. An optional stuck-at fault can be injected on one gate. The block lets the chip checker's pass and fail paths be exercised in hardware loopback. The top level performs the tristating from `pin_out` and `pin_oe`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `pin_in`; legal range 2..3.
- `DELAY_MAX`, default 15: depth of the propagation delay line; `delay` must be ≤ `DELAY_MAX`.

Ports:
- `Clk`, in, 1: the single clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: level. 1 = emulate the chip; 0 = release all pins.
- `chip_sel`, in, 2: 0 = 7400 NAND, 1 = 7402 NOR, 2 = 7408 AND, 3 = 7486 XOR.
- `delay`, in, 4: extra output latency in cycles, 0..`DELAY_MAX`.
- `fault_en`, in, 1: enables stuck-at injection.
- `fault_gate`, in, 2: gate A..D (0..3) that receives the fault.
- `fault_val`, in, 1: value the faulted gate output is stuck at.
- `pin_in`, in, [13:1]: pin levels seen at the header. Bit 7 (GND) is ignored.
- `pin_out`, out, [13:1]: values to drive onto the pins.
- `pin_oe`, out, [13:1]: per-pin drive enables.
- `active`, out, 1: high while in state RUN.
- `trans_cnt`, out, 16: saturating count of gate-result changes.

## Operation
Pin map:
- 7400, 7408, 7486:
  - A: inputs 1, 2; output 3
  - B: inputs 4, 5; output 6
  - C: inputs 9, 10; output 8
  - D: inputs 12, 13; output 11
- 7402:
  - A: output 1; inputs 2, 3
  - B: output 4; inputs 5, 6
  - C: output 10; inputs 8, 9
  - D: output 13; inputs 11, 12

States:
- IDLE:
  - `pin_oe` = 0, `pin_out` = 0, `active` = 0.
  - Delay line cleared to 0; `trans_cnt` holds its value.
  - On `enable`=1: latch `chip_sel`, `delay`, `fault_*` into config registers, clear `trans_cnt`, go to RUN.
- RUN:
  - `pin_oe` = output mask of the latched chip, for example {1,4,10,13} for the 7402. All other bits are 0.
  - `pin_out` bits at output pins come from the delay-line tap; all other bits are 0.
  - Config inputs are ignored while in RUN.
  - On `enable`=0: go to IDLE. `pin_oe` drops on that same edge.

Datapath, evaluated every cycle in RUN:
- The 4-bit gate result is computed from the synchronized pins.
- If `fault_en` is latched, the faulted gate's bit is forced to `fault_val`.
- The result feeds delay-line stage 0 and the transition detector.
- `trans_cnt` increments by 1 on any cycle where the post-fault result differs from its previous-cycle value. It saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, `pin_oe` = 0, `pin_out` = 0, `active` = 0, `trans_cnt` = 0, delay line 0, synchronizers 0, config registers 0.
- Latency: if a `pin_in` change is first captured by the synchronizer at edge k, `pin_out` reflects it at edge k + `SYNC_STAGES` + `delay`. With defaults and `delay`=0 this is k+2.
- `pin_out` is fully registered, with no combinational path from `pin_in`.
- After RUN entry, outputs read 0 until the delay line fills, i.e. for `SYNC_STAGES` + `delay` cycles. This interval is defined behaviour.
- Transition detection is not masked at RUN entry. The first computed result is compared against the cleared previous value (0) and counts if they differ.
- `enable` toggled 1→0→1 on consecutive cycles: one IDLE cycle occurs, then config is re-latched and `trans_cnt` re-cleared.
- `Reset` asserted mid-RUN: all outputs go to their reset values immediately, without waiting for a clock edge.
- `delay` > `DELAY_MAX` at latch time is clamped to `DELAY_MAX`.

## Structure
- Package `chip_emu_pkg` holds:
  - `chip_t` enum (NAND, NOR, AND, XOR)
  - per-chip output-mask constants
  - the pin-to-gate input and output index tables
  - the gate-evaluation function
- Sub-module `gate_delay_line`:
  - 4-bit wide, `DELAY_MAX`+1 stages, tap select, synchronous clear.
  - Instantiated once.
- FSM, synchronizer, transition counter and pin mapping live in the top module.

## Test plan
- 7402, `delay`=0, pins 2=0 and 3=0 set at edge k → `pin_out[1]`=1 at edge k+2 and not before; `pin_oe` set exactly on pins {1,4,10,13}.
- 7486, `delay`=5, pin1=1 and pin2=0 at edge k → `pin_out[3]` is 0 through edge k+6 and 1 from edge k+7.
- 7408, fault on gate C stuck 0, pins 9=10=1 and 12=13=1 → `pin_out[8]`=0 and `pin_out[11]`=1.
- 7400, pin1=1, toggle pin2 ten times with 4-cycle spacing → `trans_cnt`=10 (plus 1 if the first result differs from 0). Preload the count near 0xFFFF to verify saturation.
- Change `chip_sel` mid-RUN → no effect on outputs. Deassert `enable` → `pin_oe`=0 one edge later. Re-enable → new chip's mask applied and `trans_cnt` cleared.
- Assert `Reset` mid-RUN between clock edges → `pin_oe`, `pin_out` and `active` go to 0 asynchronously. After release, the block stays in IDLE until `enable` is asserted.

Source files
------------

// File: rtl/chip_emu_pkg.sv
// Shared types, pin maps and gate evaluation for the 14-pin quad 2-input gate emulator.
package chip_emu_pkg;

    typedef enum logic [1:0] {
        CHIP_NAND = 2'd0,
        CHIP_NOR  = 2'd1,
        CHIP_AND  = 2'd2,
        CHIP_XOR  = 2'd3
    } chip_t;

    typedef logic [3:0] pin_idx_t;

    localparam logic [13:1] MASK_STD  = 13'h04A4;  // outputs on pins 3, 6, 8, 11
    localparam logic [13:1] MASK_7402 = 13'h1209;  // outputs on pins 1, 4, 10, 13

    // Indexed [layout][gate]; layout 0 = 7400/7408/7486, layout 1 = 7402.
    localparam pin_idx_t IN_A_PIN [2][4] = '{'{4'd1, 4'd4, 4'd9,  4'd12}, '{4'd2, 4'd5, 4'd8,  4'd11}};
    localparam pin_idx_t IN_B_PIN [2][4] = '{'{4'd2, 4'd5, 4'd10, 4'd13}, '{4'd3, 4'd6, 4'd9,  4'd12}};
    localparam pin_idx_t OUT_PIN  [2][4] = '{'{4'd3, 4'd6, 4'd8,  4'd11}, '{4'd1, 4'd4, 4'd10, 4'd13}};

    function automatic int layout_of(chip_t chip);
        return (chip == CHIP_NOR) ? 1 : 0;
    endfunction

    function automatic logic [13:1] output_mask(chip_t chip);
        return (chip == CHIP_NOR) ? MASK_7402 : MASK_STD;
    endfunction

    function automatic logic gate_fn(chip_t chip, logic a, logic b);
        case (chip)
            CHIP_NAND: return ~(a & b);
            CHIP_NOR:  return ~(a | b);
            CHIP_AND:  return a & b;
            default:   return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] eval_gates(chip_t chip, logic [13:1] pins);
        logic [3:0] res;
        int         lay;
        lay = layout_of(chip);
        for (int g = 0; g < 4; g++) begin
            res[g] = gate_fn(chip, pins[IN_A_PIN[lay][g]], pins[IN_B_PIN[lay][g]]);
        end
        return res;
    endfunction

    function automatic logic [13:1] place_outputs(chip_t chip, logic [3:0] res);
        logic [13:1] pins;
        int          lay;
        lay  = layout_of(chip);
        pins = '0;
        for (int g = 0; g < 4; g++) begin
            pins[OUT_PIN[lay][g]] = res[g];
        end
        return pins;
    endfunction

endpackage

// File: rtl/gate_delay_line.sv
// 4-bit shift register with selectable tap; models the chip's propagation delay.
module gate_delay_line
    import chip_emu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAP_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic [3:0]       din,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [3:0]       dout
);

    logic [3:0] stage_q [DEPTH];
    logic [3:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = clr ? 4'b0 : din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = clr ? 4'b0 : stage_q[i-1];
        end
    end

    // NOTE: every stage is reset because the output pins must read 0 straight out of reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= 4'b0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[tap_sel];

endmodule

// File: rtl/chip_emulator.sv
// Quad 2-input gate chip stand-in: synchronizes the header pins, evaluates the selected
// gate type with optional stuck-at fault, and drives outputs through a programmable delay.
module chip_emulator
    import chip_emu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_MAX   = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        enable,
    input  logic [1:0]  chip_sel,
    input  logic [3:0]  delay,
    input  logic        fault_en,
    input  logic [1:0]  fault_gate,
    input  logic        fault_val,
    input  logic [13:1] pin_in,
    output logic [13:1] pin_out,
    output logic [13:1] pin_oe,
    output logic        active,
    output logic [15:0] trans_cnt
);

    localparam int TAP_W = (DELAY_MAX < 1) ? 1 : $clog2(DELAY_MAX + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state_q, state_d;
    chip_t                  cfg_chip_q, cfg_chip_d;
    logic [3:0]             cfg_delay_q, cfg_delay_d;
    logic                   cfg_fault_en_q, cfg_fault_en_d;
    logic [1:0]             cfg_fault_gate_q, cfg_fault_gate_d;
    logic                   cfg_fault_val_q, cfg_fault_val_d;
    logic [13:1]            sync_q [SYNC_STAGES];
    logic [13:1]            sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic [3:0]             prev_q, prev_d;
    logic [15:0]            trans_cnt_q, trans_cnt_d;

    logic       run;
    logic [3:0] res_flt;
    logic [3:0] res;
    logic [3:0] tap;

    assign run = (state_q == ST_RUN);

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        cfg_chip_d       = cfg_chip_q;
        cfg_delay_d      = cfg_delay_q;
        cfg_fault_en_d   = cfg_fault_en_q;
        cfg_fault_gate_d = cfg_fault_gate_q;
        cfg_fault_val_d  = cfg_fault_val_q;
        trans_cnt_d      = trans_cnt_q;

        sync_d[0] = pin_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

        res_flt = eval_gates(cfg_chip_q, sync_q[SYNC_STAGES-1]);
        if (cfg_fault_en_q) res_flt[cfg_fault_gate_q] = cfg_fault_val_q;
        // Results stay 0 until the synchronizer has refilled after RUN entry.
        res    = (run && vld_q[SYNC_STAGES-1]) ? res_flt : 4'b0;
        prev_d = run ? res : 4'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d          = ST_RUN;
                    cfg_chip_d       = chip_t'(chip_sel);
                    cfg_delay_d      = (int'(delay) > DELAY_MAX) ? 4'(DELAY_MAX) : delay;
                    cfg_fault_en_d   = fault_en;
                    cfg_fault_gate_d = fault_gate;
                    cfg_fault_val_d  = fault_val;
                    trans_cnt_d      = 16'h0;
                end
            end
            default: begin
                if (!enable) state_d = ST_IDLE;
                if (res != prev_q && trans_cnt_q != 16'hFFFF) trans_cnt_d = trans_cnt_q + 16'h1;
            end
        endcase

        vld_d = (state_d == ST_RUN) ? {vld_q[SYNC_STAGES-2:0], 1'b1} : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= ST_IDLE;
            cfg_chip_q       <= CHIP_NAND;
            cfg_delay_q      <= 4'h0;
            cfg_fault_en_q   <= 1'b0;
            cfg_fault_gate_q <= 2'd0;
            cfg_fault_val_q  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            vld_q            <= '0;
            prev_q           <= 4'h0;
            trans_cnt_q      <= 16'h0;
        end else begin
            state_q          <= state_d;
            cfg_chip_q       <= cfg_chip_d;
            cfg_delay_q      <= cfg_delay_d;
            cfg_fault_en_q   <= cfg_fault_en_d;
            cfg_fault_gate_q <= cfg_fault_gate_d;
            cfg_fault_val_q  <= cfg_fault_val_d;
            sync_q           <= sync_d;
            vld_q            <= vld_d;
            prev_q           <= prev_d;
            trans_cnt_q      <= trans_cnt_d;
        end
    end

    gate_delay_line #(
        .DEPTH (DELAY_MAX + 1),
        .TAP_W (TAP_W)
    ) u_delay (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (~run),
        .din     (res),
        .tap_sel (TAP_W'(cfg_delay_q)),
        .dout    (tap)
    );

    assign pin_oe    = run ? output_mask(cfg_chip_q) : 13'h0;
    assign pin_out   = run ? place_outputs(cfg_chip_q, tap) : 13'h0;
    assign active    = run;
    assign trans_cnt = trans_cnt_q;

endmodule
